// File: rtl/rtc_bus_sequencer.sv
// RTC bus sequencer: turns a one-hot command from the control FSM into a
// sequence of multiplexed address/data bus accesses (ADDR, HOLD, ACCESS,
// RECOVER per access) and reports completion with a one-clock ready pulse.
module rtc_bus_sequencer #(
    parameter int unsigned PHASE_CYCLES = 4,
    parameter logic [7:0]  INIT_ADDR    = 8'h02,
    parameter logic [7:0]  XFER_ADDR    = 8'hF1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  enable,
    input  logic [47:0] wr_bank,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic        ale,
    output logic        cs_n,
    output logic        rd_n,
    output logic        wr_n,
    output logic [47:0] rd_bank,
    output logic        busy,
    output logic        ready
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_HOLD, ST_ACCESS, ST_RECOVER, ST_DONE
    } state_t;

    // Encodings equal the enable bit position of each command.
    typedef enum logic [2:0] {
        CMD_COMMIT, CMD_WR_TIMER, CMD_WR_DATE, CMD_WR_TIME, CMD_READ, CMD_INIT
    } cmd_t;

    localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);

    state_t      state_r, state_s;
    cmd_t        cmd_r, cmd_s;
    logic [7:0]  phase_r, phase_s;
    logic [2:0]  idx_r, idx_s;
    logic [47:0] wdata_r, wdata_s;
    logic        phase_last_s;

    logic [7:0]  addr_s, data_s, ad_out_s, ad_out_r;
    logic        ad_oe_s, ale_s, cs_n_s, rd_n_s, wr_n_s, busy_s, ready_s;
    logic        ad_oe_r, ale_r, cs_n_r, rd_n_r, wr_n_r, busy_r, ready_r;
    logic [47:0] rd_bank_r;

    // Highest-numbered enable bit wins.
    function automatic cmd_t decode_cmd(input logic [5:0] en);
        cmd_t c;
        if (en[5])      c = CMD_INIT;
        else if (en[4]) c = CMD_READ;
        else if (en[3]) c = CMD_WR_TIME;
        else if (en[2]) c = CMD_WR_DATE;
        else if (en[1]) c = CMD_WR_TIMER;
        else            c = CMD_COMMIT;
        return c;
    endfunction

    // Index of the final access of a command (access count minus one).
    function automatic logic [2:0] last_index(input cmd_t c);
        logic [2:0] n;
        case (c)
            CMD_INIT:     n = 3'd1;
            CMD_READ:     n = 3'd5;
            CMD_WR_TIME:  n = 3'd2;
            CMD_WR_DATE:  n = 3'd2;
            CMD_WR_TIMER: n = 3'd2;
            CMD_COMMIT:   n = 3'd0;
            default:      n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [47:0] bank, input logic [2:0] sel);
        logic [7:0] b;
        case (sel)
            3'd0:    b = bank[7:0];
            3'd1:    b = bank[15:8];
            3'd2:    b = bank[23:16];
            3'd3:    b = bank[31:24];
            3'd4:    b = bank[39:32];
            3'd5:    b = bank[47:40];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] access_addr(input cmd_t c, input logic [2:0] idx);
        logic [7:0] a;
        case (c)
            CMD_INIT:     a = INIT_ADDR;
            CMD_READ:     a = 8'h21 + {5'd0, idx};
            CMD_WR_TIME:  a = 8'h21 + {5'd0, idx};
            CMD_WR_DATE:  a = 8'h24 + {5'd0, idx};
            CMD_WR_TIMER: a = 8'h41 + {5'd0, idx};
            CMD_COMMIT:   a = XFER_ADDR;
            default:      a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] access_data(input cmd_t c, input logic [2:0] idx,
                                               input logic [47:0] bank);
        logic [7:0] d;
        case (c)
            CMD_INIT:     d = (idx == 3'd0) ? 8'h10 : 8'h00;
            CMD_WR_TIME:  d = pick_byte(bank, idx);
            CMD_WR_DATE:  d = pick_byte(bank, idx + 3'd3);
            CMD_WR_TIMER: d = pick_byte(bank, idx);
            default:      d = 8'h00;
        endcase
        return d;
    endfunction

    assign phase_last_s = (phase_r == PHASE_LAST);

    // Next-state, phase counter, access index and command snapshot logic.
    always_comb begin
        state_s = state_r;
        phase_s = 8'd0;
        idx_s   = idx_r;
        cmd_s   = cmd_r;
        wdata_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                idx_s = 3'd0;
                if (enable != 6'd0) begin
                    state_s = ST_ADDR;
                    cmd_s   = decode_cmd(enable);
                    wdata_s = wr_bank;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (phase_last_s) begin
                    state_s = ST_HOLD;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            ST_HOLD: begin
                if (phase_last_s) begin
                    state_s = ST_ACCESS;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            ST_ACCESS: begin
                if (phase_last_s) begin
                    state_s = ST_RECOVER;
                end else begin
                    phase_s = phase_r + 8'd1;
                end
            end
            ST_RECOVER: begin
                if (!phase_last_s) begin
                    phase_s = phase_r + 8'd1;
                end else if (idx_r < last_index(cmd_r)) begin
                    state_s = ST_ADDR;
                    idx_s   = idx_r + 3'd1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Bus output values for the state being entered, so the registered pins line up with it.
    always_comb begin
        addr_s   = access_addr(cmd_s, idx_s);
        data_s   = access_data(cmd_s, idx_s, wdata_s);
        ad_out_s = 8'h00;
        ad_oe_s  = 1'b0;
        ale_s    = 1'b0;
        cs_n_s   = 1'b1;
        rd_n_s   = 1'b1;
        wr_n_s   = 1'b1;
        busy_s   = 1'b0;
        ready_s  = 1'b0;
        case (state_s)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_ADDR: begin
                ale_s    = 1'b1;
                ad_oe_s  = 1'b1;
                ad_out_s = addr_s;
                busy_s   = 1'b1;
            end
            ST_HOLD: begin
                ad_oe_s  = 1'b1;
                ad_out_s = addr_s;
                busy_s   = 1'b1;
            end
            ST_ACCESS: begin
                cs_n_s = 1'b0;
                busy_s = 1'b1;
                if (cmd_s == CMD_READ) begin
                    rd_n_s = 1'b0;
                end else begin
                    wr_n_s   = 1'b0;
                    ad_oe_s  = 1'b1;
                    ad_out_s = data_s;
                end
            end
            ST_RECOVER: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                ready_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // FSM state and per-command context registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cmd_r   <= CMD_COMMIT;
            phase_r <= 8'd0;
            idx_r   <= 3'd0;
            wdata_r <= 48'd0;
        end else begin
            state_r <= state_s;
            cmd_r   <= cmd_s;
            phase_r <= phase_s;
            idx_r   <= idx_s;
            wdata_r <= wdata_s;
        end
    end

    // Registered bus pins and handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ad_out_r <= 8'h00;
            ad_oe_r  <= 1'b0;
            ale_r    <= 1'b0;
            cs_n_r   <= 1'b1;
            rd_n_r   <= 1'b1;
            wr_n_r   <= 1'b1;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
        end else begin
            ad_out_r <= ad_out_s;
            ad_oe_r  <= ad_oe_s;
            ale_r    <= ale_s;
            cs_n_r   <= cs_n_s;
            rd_n_r   <= rd_n_s;
            wr_n_r   <= wr_n_s;
            busy_r   <= busy_s;
            ready_r  <= ready_s;
        end
    end

    // Capture the RTC byte on the last clock of each read ACCESS phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_bank_r <= 48'd0;
        end else if ((state_r == ST_ACCESS) && phase_last_s && (cmd_r == CMD_READ)) begin
            for (int b = 0; b < 6; b++) begin
                if (idx_r == 3'(b)) begin
                    rd_bank_r[8*b +: 8] <= ad_in;
                end
            end
        end
    end

    assign ad_out  = ad_out_r;
    assign ad_oe   = ad_oe_r;
    assign ale     = ale_r;
    assign cs_n    = cs_n_r;
    assign rd_n    = rd_n_r;
    assign wr_n    = wr_n_r;
    assign busy    = busy_r;
    assign ready   = ready_r;
    assign rd_bank = rd_bank_r;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Directed bench for rtc_bus_sequencer with a small RTC register model and a bus protocol monitor.
module tb_rtc_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  enable;
    logic [47:0] wr_bank;
    logic [7:0]  ad_in;
    logic [7:0]  ad_out;
    logic        ad_oe, ale, cs_n, rd_n, wr_n, busy, ready;
    logic [47:0] rd_bank;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int ready_cnt = 0;
    int wr_low_cnt = 0;
    int rd_low_cnt = 0;
    int rd_fall_cnt = 0;
    int prot_err = 0;
    logic prev_ready = 1'b0, prev_ale = 1'b0;
    logic prev_cs_n = 1'b1, prev_rd_n = 1'b1, prev_wr_n = 1'b1;
    logic [7:0] rtc_addr = 8'h00;
    logic [15:0] wlog[$];

    always #5 clk = ~clk;

    rtc_bus_sequencer #(.PHASE_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .wr_bank(wr_bank), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .ale(ale), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
        .rd_bank(rd_bank), .busy(busy), .ready(ready)
    );

    // RTC register contents returned for the latched address.
    always_comb begin
        case (rtc_addr)
            8'h21:   ad_in = 8'h59;
            8'h22:   ad_in = 8'h30;
            8'h23:   ad_in = 8'h12;
            8'h24:   ad_in = 8'h15;
            8'h25:   ad_in = 8'h06;
            8'h26:   ad_in = 8'h17;
            default: ad_in = 8'h00;
        endcase
    end

    // Bus monitor: address latch, write log, strobe counts and protocol rules.
    always @(negedge clk) begin
        cyc++;
        if (ale) rtc_addr = ad_out;
        if (!rd_n && !wr_n) prot_err++;
        if (ad_oe && !rd_n) prot_err++;
        if (ready && busy) prot_err++;
        if (prev_ready && (ready || busy || ale)) prot_err++;
        if ((ale != prev_ale) && ((cs_n != prev_cs_n) || (rd_n != prev_rd_n) || (wr_n != prev_wr_n)))
            prot_err++;
        if (ready) ready_cnt++;
        if (!wr_n) wr_low_cnt++;
        if (!rd_n) rd_low_cnt++;
        if (!wr_n && prev_wr_n) wlog.push_back({rtc_addr, ad_out});
        if (!rd_n && prev_rd_n) rd_fall_cnt++;
        prev_ready = ready;
        prev_ale   = ale;
        prev_cs_n  = cs_n;
        prev_rd_n  = rd_n;
        prev_wr_n  = wr_n;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ale(output int c);
        bit found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (ale) begin
                found = 1'b1;
                break;
            end
        end
        check_val("start_seen", 64'(found), 64'd1);
        c = cyc;
    endtask

    task automatic wait_ready(output int c);
        bit found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ready) begin
                found = 1'b1;
                break;
            end
        end
        check_val("ready_seen", 64'(found), 64'd1);
        c = cyc;
    endtask

    initial begin
        int s, r, w0, r0, base, n;
        bit hit;
        logic [5:0] en;

        reset   = 1'b0;
        enable  = 6'b010000;
        wr_bank = 48'd0;

        // Reset held with READ requested: everything stays quiet.
        repeat (4) tick();
        check_val("rst_ale", 64'(ale), 64'd0);
        check_val("rst_cs_n", 64'(cs_n), 64'd1);
        check_val("rst_rd_n", 64'(rd_n), 64'd1);
        check_val("rst_wr_n", 64'(wr_n), 64'd1);
        check_val("rst_ad_oe", 64'(ad_oe), 64'd0);
        check_val("rst_ad_out", 64'(ad_out), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_ready", 64'(ready), 64'd0);
        check_val("rst_rd_bank", 64'(rd_bank), 64'd0);
        check_val("rst_no_strobes", 64'(rd_low_cnt + wr_low_cnt), 64'd0);

        // Release: first ALE on the edge right after release.
        reset = 1'b1;
        tick();
        check_val("first_ale", 64'(ale), 64'd1);
        check_val("first_busy", 64'(busy), 64'd1);
        check_val("first_addr", 64'(ad_out), 64'h21);
        s = cyc;
        wait_ready(r);
        check_val("read_latency", 64'(r - s), 64'd48);
        check_val("read_bank", 64'(rd_bank), 64'h170615123059);
        check_val("read_rd_low", 64'(rd_low_cnt), 64'd12);
        check_val("read_ready_cnt", 64'(ready_cnt), 64'd1);
        tick();
        check_val("idle_after_done", 64'({ale, busy, ready}), 64'd0);
        tick();
        check_val("poll_restart_ale", 64'(ale), 64'd1);
        enable = 6'd0;
        wait_ready(r);
        check_val("poll_ready_cnt", 64'(ready_cnt), 64'd2);

        // WR_TIME: three writes of bytes 0..2.
        tick();
        wlog.delete();
        w0 = wr_low_cnt;
        r0 = rd_low_cnt;
        wr_bank = 48'h000000_230745;
        enable  = 6'b001000;
        wait_ale(s);
        enable = 6'd0;
        wait_ready(r);
        check_val("wrtime_latency", 64'(r - s), 64'd24);
        check_val("wrtime_count", 64'(wlog.size()), 64'd3);
        check_val("wrtime_w0", 64'(wlog[0]), 64'h2145);
        check_val("wrtime_w1", 64'(wlog[1]), 64'h2207);
        check_val("wrtime_w2", 64'(wlog[2]), 64'h2323);
        check_val("wrtime_wr_low", 64'(wr_low_cnt - w0), 64'd6);
        check_val("wrtime_rd_low", 64'(rd_low_cnt - r0), 64'd0);

        // Priority and snapshot: INIT beats COMMIT, mid-command changes ignored.
        tick();
        wlog.delete();
        wr_bank = 48'hAABBCCDDEEFF;
        enable  = 6'b100001;
        wait_ale(s);
        check_val("init_addr", 64'(ad_out), 64'h02);
        enable  = 6'b000100;
        wr_bank = 48'hFFFFFFFFFFFF;
        wait_ready(r);
        enable = 6'd0;
        check_val("init_latency", 64'(r - s), 64'd16);
        check_val("init_count", 64'(wlog.size()), 64'd2);
        check_val("init_w0", 64'(wlog[0]), 64'h0210);
        check_val("init_w1", 64'(wlog[1]), 64'h0200);
        repeat (3) tick();
        check_val("init_no_restart", 64'({ale, busy}), 64'd0);

        // Abort during the third READ ACCESS.
        enable = 6'b010000;
        base = rd_fall_cnt;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rd_fall_cnt == base + 3) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("abort_reached", 64'(hit), 64'd1);
        reset = 1'b0;
        #1;
        check_val("abort_cs_n", 64'(cs_n), 64'd1);
        check_val("abort_rd_n", 64'(rd_n), 64'd1);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_ad_oe", 64'(ad_oe), 64'd0);
        check_val("abort_rd_bank", 64'(rd_bank), 64'd0);
        enable = 6'd0;
        base = ready_cnt;
        tick();
        reset = 1'b1;
        repeat (10) tick();
        check_val("abort_no_ready", 64'(ready_cnt), 64'(base));
        check_val("abort_idle", 64'(busy), 64'd0);

        // Random commands: latency follows the winning command's access count.
        for (int i = 0; i < 8; i++) begin
            en = 6'($urandom_range(1, 63));
            wr_bank = {16'($urandom), 32'($urandom)};
            if (en[5])                    n = 2;
            else if (en[4])               n = 6;
            else if (en[3] | en[2] | en[1]) n = 3;
            else                          n = 1;
            enable = en;
            wait_ale(s);
            enable = 6'd0;
            wait_ready(r);
            check_val("rand_latency", 64'(r - s), 64'(8 * n));
        end
        repeat (3) tick();
        check_val("protocol", 64'(prot_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
